// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: load/start sequencer for an NUM_PE-wide systolic PE column.
// A command (row_len, col_tiles) runs PRELOAD -> STREAM -> (RELOAD -> STREAM)* -> DONE,
// issuing one-hot operand-read, start and filter-row-read strobes each cycle.
// Optional feature macro: SEQ_ABORT_EN adds an 'abort' input that returns the
// sequencer to IDLE from any busy state without pulsing done.
module systolic_seq_ctrl #(
  parameter int NUM_PE       = 5,
  parameter int FILT_ROWS    = 3,
  parameter int PRELOAD_ROWS = 3,
  parameter int CNT_W        = 5
) (
  input  logic                 clk,
  input  logic                 nRST,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [CNT_W-1:0]     cmd_row_len,
  input  logic [CNT_W-1:0]     cmd_col_tiles,
  input  logic                 stall,
`ifdef SEQ_ABORT_EN
  input  logic                 abort,
`endif
  output logic [NUM_PE-1:0]    pe_read,
  output logic [NUM_PE-1:0]    pe_start,
  output logic [FILT_ROWS-1:0] filt_read,
  output logic                 busy,
  output logic                 done,
  output logic [CNT_W-1:0]     tile_idx
);

  localparam int SW = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
  localparam int PW = $clog2(PRELOAD_ROWS + 1);
  localparam int RW = (CNT_W > PW) ? CNT_W : PW;

  localparam logic [SW-1:0] S_LAST   = SW'(NUM_PE - 1);  // handoff slot in (re)load, last slot in stream
  localparam logic [SW-1:0] S_PLAST  = SW'(NUM_PE - 2);  // last read slot of a (re)load row
  localparam logic [SW-1:0] S_FILT   = SW'(FILT_ROWS);
  localparam logic [RW-1:0] PRE_LAST = RW'(PRELOAD_ROWS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRELOAD = 3'd1,
    STREAM  = 3'd2,
    RELOAD  = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t           r_state, w_state;
  logic [SW-1:0]    r_slot, w_slot;
  logic [RW-1:0]    r_row, w_row;
  logic [CNT_W-1:0] r_tile, w_tile;
  logic [CNT_W-1:0] r_row_len, w_row_len;
  logic [CNT_W-1:0] r_col_tiles, w_col_tiles;

  logic w_load;      // PRELOAD or RELOAD
  logic w_handoff;   // extra cycle after the final (re)load slot
  logic w_pre_last;  // final (re)load row
  logic w_str_last;  // final stream row of the current tile
  logic w_tile_last;
  logic w_abort;

`ifdef SEQ_ABORT_EN
  assign w_abort = abort && (r_state != IDLE);
`else
  assign w_abort = 1'b0;
`endif

  assign w_load      = (r_state == PRELOAD) || (r_state == RELOAD);
  assign w_handoff   = w_load && (r_slot == S_LAST);
  assign w_pre_last  = (r_row == PRE_LAST);
  assign w_str_last  = (r_row == (RW'(r_row_len) - RW'(1)));
  assign w_tile_last = ((r_tile + CNT_W'(1)) == r_col_tiles);

  assign busy     = (r_state != IDLE);
  assign tile_idx = r_tile;

  // State register
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) r_state <= IDLE;
    else       r_state <= w_state;
  end

  // Slot/row/tile counters and latched command fields
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      r_slot      <= '0;
      r_row       <= '0;
      r_tile      <= '0;
      r_row_len   <= '0;
      r_col_tiles <= '0;
    end else begin
      r_slot      <= w_slot;
      r_row       <= w_row;
      r_tile      <= w_tile;
      r_row_len   <= w_row_len;
      r_col_tiles <= w_col_tiles;
    end
  end

  // Next-state, counter advance and strobe decode; stall and abort override last
  always_comb begin
    w_state     = r_state;
    w_slot      = r_slot;
    w_row       = r_row;
    w_tile      = r_tile;
    w_row_len   = r_row_len;
    w_col_tiles = r_col_tiles;
    pe_read     = '0;
    pe_start    = '0;
    filt_read   = '0;
    done        = 1'b0;
    cmd_ready   = 1'b0;

    unique case (r_state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          // zero-length fields run as length one
          w_row_len   = (cmd_row_len   == '0) ? CNT_W'(1) : cmd_row_len;
          w_col_tiles = (cmd_col_tiles == '0) ? CNT_W'(1) : cmd_col_tiles;
          w_slot      = '0;
          w_row       = '0;
          w_tile      = '0;
          w_state     = PRELOAD;
        end
      end

      PRELOAD, RELOAD: begin
        if (w_handoff) begin
          pe_start[NUM_PE-1] = 1'b1;
          w_slot  = '0;
          w_row   = '0;
          w_state = STREAM;
        end else begin
          pe_read = NUM_PE'(1) << r_slot;
          // the last PE's operand is read alongside its neighbour's
          if (r_slot == S_PLAST) pe_read[NUM_PE-1] = 1'b1;
          if ((r_state == PRELOAD) && (r_slot < S_FILT))
            filt_read = FILT_ROWS'(1) << r_slot;
          if (w_pre_last) pe_start = NUM_PE'(1) << r_slot;
          if (r_slot == S_PLAST) begin
            if (w_pre_last) begin
              w_slot = S_LAST;
            end else begin
              w_slot = '0;
              w_row  = r_row + RW'(1);
            end
          end else begin
            w_slot = r_slot + SW'(1);
          end
        end
      end

      STREAM: begin
        pe_read  = NUM_PE'(1) << r_slot;
        pe_start = NUM_PE'(1) << r_slot;
        if (r_slot == S_LAST) begin
          w_slot = '0;
          if (w_str_last) begin
            w_row = '0;
            if (w_tile_last) begin
              w_state = DONE;
            end else begin
              w_tile  = r_tile + CNT_W'(1);
              w_state = RELOAD;
            end
          end else begin
            w_row = r_row + RW'(1);
          end
        end else begin
          w_slot = r_slot + SW'(1);
        end
      end

      DONE: begin
        done    = 1'b1;
        w_state = IDLE;
      end

      default: w_state = IDLE;
    endcase

    // stall freezes everything and silences strobes; a pending done waits
    if (stall) begin
      w_state     = r_state;
      w_slot      = r_slot;
      w_row       = r_row;
      w_tile      = r_tile;
      w_row_len   = r_row_len;
      w_col_tiles = r_col_tiles;
      pe_read     = '0;
      pe_start    = '0;
      filt_read   = '0;
      done        = 1'b0;
      cmd_ready   = 1'b0;
    end

    // abort wins over stall and drops the command without a done pulse
    if (w_abort) begin
      w_state   = IDLE;
      w_slot    = '0;
      w_row     = '0;
      w_tile    = '0;
      pe_read   = '0;
      pe_start  = '0;
      filt_read = '0;
      done      = 1'b0;
      cmd_ready = 1'b0;
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl with default parameters.
// Cycle n of a command is the n-th clock window after the accept cycle (cycle 0);
// inputs change 1 time unit after each rising edge and outputs are sampled 1 unit later.
module tb_systolic_seq_ctrl;

  logic       clk = 1'b0;
  logic       nRST;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [4:0] cmd_row_len;
  logic [4:0] cmd_col_tiles;
  logic       stall;
`ifdef SEQ_ABORT_EN
  logic       abort;
`endif
  logic [4:0] pe_read;
  logic [4:0] pe_start;
  logic [2:0] filt_read;
  logic       busy;
  logic       done;
  logic [4:0] tile_idx;

  int n_pass  = 0;
  int n_total = 0;
  int prev_tile = 0;

  typedef struct {
    logic [4:0] rd;
    logic [4:0] st;
    logic [2:0] fr;
    logic       dn;
    logic       by;
    logic       rdy;
    logic [4:0] tl;
  } exp_t;

  // Hand-written (re)load cycle table: 3 rows x 4 slots, then the handoff cycle
  logic [4:0] pre_rd [13] = '{5'h01, 5'h02, 5'h04, 5'h18, 5'h01, 5'h02, 5'h04, 5'h18,
                              5'h01, 5'h02, 5'h04, 5'h18, 5'h00};
  logic [4:0] pre_st [13] = '{5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00, 5'h00,
                              5'h01, 5'h02, 5'h04, 5'h08, 5'h10};
  logic [2:0] pre_fr [13] = '{3'h1, 3'h2, 3'h4, 3'h0, 3'h1, 3'h2, 3'h4, 3'h0,
                              3'h1, 3'h2, 3'h4, 3'h0, 3'h0};
  logic [4:0] str_tab [5] = '{5'h01, 5'h02, 5'h04, 5'h08, 5'h10};

  systolic_seq_ctrl #(
    .NUM_PE(5), .FILT_ROWS(3), .PRELOAD_ROWS(3), .CNT_W(5)
  ) dut (
    .clk           (clk),
    .nRST          (nRST),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_row_len   (cmd_row_len),
    .cmd_col_tiles (cmd_col_tiles),
    .stall         (stall),
`ifdef SEQ_ABORT_EN
    .abort         (abort),
`endif
    .pe_read       (pe_read),
    .pe_start      (pe_start),
    .filt_read     (filt_read),
    .busy          (busy),
    .done          (done),
    .tile_idx      (tile_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
  endtask

  task automatic chk_idle(input string tag, input logic [4:0] tl);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd1);
    chk({tag, " busy"},      32'(busy),      32'd0);
    chk({tag, " done"},      32'(done),      32'd0);
    chk({tag, " pe_read"},   32'(pe_read),   32'd0);
    chk({tag, " pe_start"},  32'(pe_start),  32'd0);
    chk({tag, " filt_read"}, 32'(filt_read), 32'd0);
    chk({tag, " tile_idx"},  32'(tile_idx),  32'(tl));
  endtask

  // Runs one command from its accept cycle through the first IDLE cycle after done.
  task automatic run_cmd(input string tag, input logic [4:0] rl_in, input logic [4:0] ct_in,
                         input int stall_at, input int stall_len, input int exp_done,
                         input bit hold_valid);
    exp_t q[$];
    exp_t e;
    int   rl, ct, idx, done_cyc, c;
    bit   stl;
    rl = (rl_in == 5'd0) ? 1 : int'(rl_in);
    ct = (ct_in == 5'd0) ? 1 : int'(ct_in);
    e = '{rd: 5'h0, st: 5'h0, fr: 3'h0, dn: 1'b0, by: 1'b0, rdy: 1'b1, tl: 5'(prev_tile)};
    q.push_back(e);
    for (int t = 0; t < ct; t++) begin
      for (int k = 0; k < 13; k++) begin
        e = '{rd: pre_rd[k], st: pre_st[k], fr: (t == 0) ? pre_fr[k] : 3'h0,
              dn: 1'b0, by: 1'b1, rdy: 1'b0, tl: 5'(t)};
        q.push_back(e);
      end
      for (int k = 0; k < rl * 5; k++) begin
        e = '{rd: str_tab[k % 5], st: str_tab[k % 5], fr: 3'h0,
              dn: 1'b0, by: 1'b1, rdy: 1'b0, tl: 5'(t)};
        q.push_back(e);
      end
    end
    e = '{rd: 5'h0, st: 5'h0, fr: 3'h0, dn: 1'b1, by: 1'b1, rdy: 1'b0, tl: 5'(ct - 1)};
    q.push_back(e);
    e = '{rd: 5'h0, st: 5'h0, fr: 3'h0, dn: 1'b0, by: 1'b0, rdy: 1'b1, tl: 5'(ct - 1)};
    q.push_back(e);

    idx = 0;
    done_cyc = -1;
    c = 0;
    while (idx < q.size()) begin
      @(posedge clk);
      #1;
      stl       = (c >= stall_at) && (c < stall_at + stall_len);
      stall     = stl;
      cmd_valid = (c == 0) || hold_valid;
      // fields outside the accept cycle are junk unless the command is being held
      cmd_row_len   = (c == 0 || hold_valid) ? rl_in : 5'h1F;
      cmd_col_tiles = (c == 0 || hold_valid) ? ct_in : 5'h1F;
      #1;
      e = q[idx];
      if (stl) begin
        e.rd = 5'h0; e.st = 5'h0; e.fr = 3'h0; e.dn = 1'b0; e.rdy = 1'b0;
      end
      chk($sformatf("%s c%0d pe_read", tag, c),   32'(pe_read),   32'(e.rd));
      chk($sformatf("%s c%0d pe_start", tag, c),  32'(pe_start),  32'(e.st));
      chk($sformatf("%s c%0d filt_read", tag, c), 32'(filt_read), 32'(e.fr));
      chk($sformatf("%s c%0d done", tag, c),      32'(done),      32'(e.dn));
      chk($sformatf("%s c%0d busy", tag, c),      32'(busy),      32'(e.by));
      chk($sformatf("%s c%0d cmd_ready", tag, c), 32'(cmd_ready), 32'(e.rdy));
      chk($sformatf("%s c%0d tile_idx", tag, c),  32'(tile_idx),  32'(e.tl));
      if (done === 1'b1 && done_cyc < 0) done_cyc = c;
      if (!stl) idx++;
      c++;
      if (c > 200) begin
        chk({tag, " cycle budget"}, 32'(c), 32'(exp_done + 1));
        break;
      end
    end
    chk({tag, " done cycle"}, 32'(done_cyc), 32'(exp_done));
    stall     = 1'b0;
    prev_tile = ct - 1;
  endtask

  initial begin
    nRST = 1'b0; cmd_valid = 1'b0; stall = 1'b0;
    cmd_row_len = 5'd0; cmd_col_tiles = 5'd0;
`ifdef SEQ_ABORT_EN
    abort = 1'b0;
`endif
    #2;
    chk_idle("in reset", 5'd0);
    @(posedge clk); @(posedge clk); #1;
    nRST = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk_idle($sformatf("idle c%0d", i), 5'd0);
    end

    // basic 2-row, 1-tile command
    run_cmd("A", 5'd2, 5'd1, 1000, 0, 24, 1'b0);
    // two tiles: reload with filt_read quiet and tile_idx=1
    run_cmd("B", 5'd2, 5'd2, 1000, 0, 47, 1'b0);
    // 3-cycle stall at cycle 5
    run_cmd("S", 5'd2, 5'd1, 5, 3, 27, 1'b0);
    // zero fields treated as one; cmd_valid held through busy, re-accepted at cycle 20
    run_cmd("Z", 5'd0, 5'd0, 1000, 0, 19, 1'b1);

    // the re-accepted command is now running: reset it mid-stream at its cycle 15
    for (int k = 1; k <= 15; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      #1;
      if (k == 1)  chk("R c1 pe_read", 32'(pe_read), 32'h01);
      if (k == 1)  chk("R c1 busy", 32'(busy), 32'd1);
      if (k == 15) chk("R c15 pe_read before reset", 32'(pe_read), 32'h02);
    end
    nRST = 1'b0;
    #1;
    chk_idle("R in reset", 5'd0);
    @(posedge clk); #1;
    nRST = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #2;
      chk_idle($sformatf("R after reset c%0d", i), 5'd0);
    end
    prev_tile = 0;

`ifdef SEQ_ABORT_EN
    // abort mid-stream at cycle 15
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_row_len = 5'd2; cmd_col_tiles = 5'd1;
    for (int k = 1; k <= 16; k++) begin
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      abort     = (k == 15);
      #1;
      if (k == 14) chk("X c14 pe_read", 32'(pe_read), 32'h01);
      if (k == 15) begin
        chk("X c15 pe_read", 32'(pe_read), 32'h00);
        chk("X c15 pe_start", 32'(pe_start), 32'h00);
        chk("X c15 done", 32'(done), 32'd0);
      end
      if (k == 16) chk_idle("X c16", 5'd0);
    end
    abort = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #2;
      chk(i == 0 ? "X after done" : "X after done+", 32'(done), 32'd0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
